// File: rtl/axil_reg_selftest_master_if.sv
// AXI4-Lite bus bundle between the register self-test master and the IP under test.
interface axil_reg_selftest_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_reg_selftest_master.sv
// AXI4-Lite master that writes a pattern to NUM_REGS registers, reads them back and scores the result.
// Optional per-transaction watchdog enabled by defining AXIL_SELFTEST_TIMEOUT_EN.
module axil_reg_selftest_master #(
  parameter int                    NUM_REGS       = 4,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    ADDR_STRIDE    = DATA_WIDTH / 8,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       start,
  input  logic [1:0]                 mode,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                err_count,
  output logic [ADDR_WIDTH-1:0]      first_err_addr,
  output logic [DATA_WIDTH-1:0]      first_err_data,
  axil_reg_selftest_master_if.master m_axi
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  if (NUM_REGS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axil_reg_selftest_master: NUM_REGS and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  state_t state_q, state_d;

  logic [IDX_W-1:0]      idx_q, idx_nxt;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  aw_done_q, w_done_q;
  logic                  aw_hs, w_hs, last, mismatch, load, step, timeout;
  logic [1:0]            err_add;
  logic [DATA_WIDTH-1:0] err_data;

  function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + ADDR_WIDTH'(i) * ADDR_WIDTH'(ADDR_STRIDE);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m, input logic [IDX_W-1:0] i,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] inc, res;
    inc = DATA_WIDTH'(i) + DATA_WIDTH'(1);
    case (m)
      2'd0:    res = inc;
      2'd1:    res = DATA_WIDTH'(1) << (int'(i) % DATA_WIDTH);
      2'd2:    res = ~inc;
      default: res = DATA_WIDTH'(a);
    endcase
    return res;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign busy = (state_q == WR) || (state_q == WR_RESP) || (state_q == RD_ADDR) || (state_q == RD_DATA);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == 16'd0);

  assign m_axi.awaddr = addr_q;
  assign m_axi.araddr = addr_q;
  assign m_axi.wdata  = wdata_q;
  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;
  assign m_axi.wstrb  = '1;

  assign aw_hs    = (state_q == WR) && !aw_done_q && m_axi.awready;
  assign w_hs     = (state_q == WR) && !w_done_q && m_axi.wready;
  assign last     = (idx_q == IDX_W'(NUM_REGS - 1));
  assign idx_nxt  = last ? '0 : idx_q + IDX_W'(1);
  assign mismatch = (m_axi.rdata != wdata_q);

`ifdef AXIL_SELFTEST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  // Reloads on every state change, so it bounds each transaction phase separately.
  always_ff @(posedge ACLK) begin
    if (!ARESETN || state_d != state_q) wd_q <= '0;
    else if (busy)                      wd_q <= wd_q + WD_W'(1);
  end

  assign timeout = busy && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    step     = 1'b0;
    err_add  = 2'd0;
    err_data = '0;
    m_axi.awvalid = (state_q == WR) && !aw_done_q;
    m_axi.wvalid  = (state_q == WR) && !w_done_q;
    m_axi.bready  = (state_q == WR_RESP);
    m_axi.arvalid = (state_q == RD_ADDR);
    m_axi.rready  = (state_q == RD_DATA);
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = WR;
        load    = 1'b1;
      end
      WR: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      WR_RESP: if (m_axi.bvalid) begin
        err_add = {1'b0, m_axi.bresp != 2'b00};
        step    = 1'b1;
        state_d = last ? RD_ADDR : WR;
      end
      RD_ADDR: if (m_axi.arready) state_d = RD_DATA;
      RD_DATA: if (m_axi.rvalid) begin
        err_add  = 2'(m_axi.rresp != 2'b00) + 2'(mismatch);
        err_data = mismatch ? m_axi.rdata : '0;
        step     = 1'b1;
        state_d  = last ? DONE : RD_ADDR;
      end
      default: state_d = IDLE;
    endcase
    // An expired watchdog wins over any handshake landing in the same cycle.
    if (timeout) begin
      state_d  = DONE;
      step     = 1'b0;
      err_add  = 2'd1;
      err_data = '0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      idx_q          <= '0;
      mode_q         <= 2'd0;
      addr_q         <= '0;
      wdata_q        <= '0;
      err_count      <= 16'd0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      aw_done_q <= (state_q == WR) && (state_d == WR) && (aw_done_q || aw_hs);
      w_done_q  <= (state_q == WR) && (state_d == WR) && (w_done_q || w_hs);
      if (load) begin
        mode_q         <= mode;
        idx_q          <= '0;
        addr_q         <= reg_addr(IDX_W'(0));
        wdata_q        <= pattern(mode, IDX_W'(0), reg_addr(IDX_W'(0)));
        err_count      <= 16'd0;
        first_err_addr <= '0;
        first_err_data <= '0;
      end else begin
        // err_count only reaches zero again on a new start, so zero marks the first error.
        if (err_add != 2'd0) begin
          err_count <= sat_add(err_count, err_add);
          if (err_count == 16'd0) begin
            first_err_addr <= addr_q;
            first_err_data <= err_data;
          end
        end
        if (step) begin
          idx_q   <= idx_nxt;
          addr_q  <= reg_addr(idx_nxt);
          wdata_q <= pattern(mode_q, idx_nxt, reg_addr(idx_nxt));
        end
      end
    end
  end
endmodule

// File: tb/tb_axil_reg_selftest_master.sv
// Directed bench for axil_reg_selftest_master with a small RAM-backed AXI4-Lite slave.
module tb_axil_reg_selftest_master;
  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr, first_err_data;

  int total = 0;
  int bad = 0;

  logic        stall_en = 1'b0, stuck_en = 1'b0, slverr_en = 1'b0, ar_block = 1'b0, mem_clr = 1'b0;
  logic [31:0] mem [16];
  logic [2:0]  aw_wait, w_wait, ar_wait;
  logic        aw_got, w_got;
  logic [31:0] wa_q, wd_q, wa_cur, wd_cur, wd_val;
  logic        aw_hit, w_hit, ar_hit;

  axil_reg_selftest_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_reg_selftest_master #(
    .NUM_REGS(NR), .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h0),
    .ADDR_STRIDE(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(clk), .ARESETN(rstn), .start(start), .mode(mode),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  // RAM slave: ready stalls, stuck bit at 0x8, SLVERR writes, blocked read address.
  assign bus.awready = bus.awvalid && (aw_wait == 3'd0);
  assign bus.wready  = bus.wvalid && (w_wait == 3'd0);
  assign bus.arready = bus.arvalid && (ar_wait == 3'd0) && !ar_block;
  assign aw_hit = bus.awvalid && bus.awready;
  assign w_hit  = bus.wvalid && bus.wready;
  assign ar_hit = bus.arvalid && bus.arready;
  assign wa_cur = aw_got ? wa_q : bus.awaddr;
  assign wd_cur = w_got ? wd_q : bus.wdata;
  assign wd_val = (stuck_en && wa_cur == 32'h8) ? (wd_cur & ~32'h1) : wd_cur;

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 16; i++) mem[i] <= 32'hDEAD_BEEF;
    if (!rstn) begin
      aw_got <= 1'b0; w_got <= 1'b0; wa_q <= 32'h0; wd_q <= 32'h0;
      aw_wait <= 3'd0; w_wait <= 3'd0; ar_wait <= 3'd0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= 32'h0;
    end else begin
      if (aw_hit) begin
        wa_q <= bus.awaddr; aw_got <= 1'b1;
        aw_wait <= stall_en ? 3'($urandom_range(0, 5)) : 3'd0;
      end else if (!stall_en) aw_wait <= 3'd0;
      else if (bus.awvalid && aw_wait != 3'd0) aw_wait <= aw_wait - 3'd1;
      if (w_hit) begin
        wd_q <= bus.wdata; w_got <= 1'b1;
        w_wait <= stall_en ? 3'($urandom_range(0, 5)) : 3'd0;
      end else if (!stall_en) w_wait <= 3'd0;
      else if (bus.wvalid && w_wait != 3'd0) w_wait <= w_wait - 3'd1;
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if ((aw_got || aw_hit) && (w_got || w_hit)) begin
        mem[wa_cur[5:2]] <= wd_val;
        bus.bvalid <= 1'b1;
        bus.bresp <= slverr_en ? 2'b10 : 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (ar_hit) begin
        bus.rvalid <= 1'b1; bus.rdata <= mem[bus.araddr[5:2]]; bus.rresp <= 2'b00;
        ar_wait <= stall_en ? 3'($urandom_range(0, 5)) : 3'd0;
      end else if (!stall_en) ar_wait <= 3'd0;
      else if (bus.arvalid && ar_wait != 3'd0) ar_wait <= ar_wait - 3'd1;
    end
  end

  task automatic clear_mem;
    @(negedge clk) mem_clr = 1'b1;
    @(negedge clk) mem_clr = 1'b0;
  endtask

  // Leaves the bench at the negedge after the edge that sampled start.
  task automatic run_start(input logic [1:0] m);
    @(negedge clk);
    mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 1;
    while (!done && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL wait_done: done=%b after %0d cycles, want 1", done, cyc);
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if ({busy, done, pass} !== 3'b000) begin
      bad++; $display("FAIL %s_status: busy/done/pass=%b want 000", tag, {busy, done, pass});
    end
    total++;
    if (err_count !== 16'h0 || first_err_addr !== 32'h0 || first_err_data !== 32'h0) begin
      bad++; $display("FAIL %s_err: err=%h addr=%h data=%h want 0", tag, err_count, first_err_addr, first_err_data);
    end
    total++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
      bad++; $display("FAIL %s_valids: %b want 00000", tag,
                      {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
    end
    total++;
    if (bus.awaddr !== 32'h0 || bus.araddr !== 32'h0 || bus.wdata !== 32'h0) begin
      bad++; $display("FAIL %s_buses: awaddr=%h araddr=%h wdata=%h want 0", tag, bus.awaddr, bus.araddr, bus.wdata);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rstn = 1'b1;
  endtask

  task automatic test_mode0_zero_wait;
    int cyc;
    clear_mem();
    run_start(2'd0);
    total++;
    if ({busy, bus.awvalid, bus.wvalid} !== 3'b111 || bus.awaddr !== 32'h0 || bus.wdata !== 32'h1) begin
      bad++; $display("FAIL first_write: busy/awv/wv=%b awaddr=%h wdata=%h want 111 0 1",
                      {busy, bus.awvalid, bus.wvalid}, bus.awaddr, bus.wdata);
    end
    total++;
    if (bus.awprot !== 3'b000 || bus.arprot !== 3'b000 || bus.wstrb !== 4'hF) begin
      bad++; $display("FAIL prot_strb: awprot=%b arprot=%b wstrb=%h want 000 000 f", bus.awprot, bus.arprot, bus.wstrb);
    end
    wait_done(200, cyc);
    total++;
    if (cyc !== 17) begin
      bad++; $display("FAIL latency: got %0d cycles want 17", cyc);
    end
    total++;
    if (pass !== 1'b1 || err_count !== 16'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL mode0_result: pass=%b err=%h busy=%b want 1 0 0", pass, err_count, busy);
    end
    for (int i = 0; i < NR; i++) begin
      total++;
      if (mem[i] !== 32'(i + 1)) begin
        bad++; $display("FAIL mode0_mem%0d: got %h want %h", i, mem[i], 32'(i + 1));
      end
    end
  endtask

  task automatic test_stall_mode1;
    int cyc, viol, stalls;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    stall_en = 1'b1;
    viol = 0; stalls = 0; cyc = 0;
    clear_mem();
    run_start(2'd1);
    while (!done && cyc < 400) begin
      p_awv = bus.awvalid; p_awr = bus.awready; p_awaddr = bus.awaddr;
      p_wv = bus.wvalid; p_wr = bus.wready; p_wdata = bus.wdata;
      p_arv = bus.arvalid; p_arr = bus.arready; p_araddr = bus.araddr;
      @(negedge clk);
      cyc++;
      if (p_awv && !p_awr) begin
        stalls++;
        if (!bus.awvalid || bus.awaddr !== p_awaddr) viol++;
      end
      if (p_wv && !p_wr) begin
        stalls++;
        if (!bus.wvalid || bus.wdata !== p_wdata) viol++;
      end
      if (p_arv && !p_arr) begin
        stalls++;
        if (!bus.arvalid || bus.araddr !== p_araddr) viol++;
      end
    end
    stall_en = 1'b0;
    total++;
    if (viol !== 0 || stalls == 0) begin
      bad++; $display("FAIL stall_stable: violations=%0d stalls=%0d want 0 and >0", viol, stalls);
    end
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || err_count !== 16'h0) begin
      bad++; $display("FAIL stall_result: done=%b pass=%b err=%h want 1 1 0", done, pass, err_count);
    end
    for (int i = 0; i < NR; i++) begin
      total++;
      if (mem[i] !== (32'h1 << i)) begin
        bad++; $display("FAIL mode1_mem%0d: got %h want %h", i, mem[i], 32'h1 << i);
      end
    end
  endtask

  task automatic test_bresp_err;
    int cyc;
    slverr_en = 1'b1;
    run_start(2'd0);
    wait_done(200, cyc);
    slverr_en = 1'b0;
    total++;
    if (err_count !== 16'd4 || pass !== 1'b0) begin
      bad++; $display("FAIL bresp_count: err=%h pass=%b want 4 0", err_count, pass);
    end
    total++;
    if (first_err_addr !== 32'h0 || first_err_data !== 32'h0) begin
      bad++; $display("FAIL bresp_first: addr=%h data=%h want 0 0", first_err_addr, first_err_data);
    end
  endtask

  task automatic test_stuck_bit;
    int cyc;
    stuck_en = 1'b1;
    clear_mem();
    run_start(2'd0);
    wait_done(200, cyc);
    stuck_en = 1'b0;
    total++;
    if (err_count !== 16'd1 || pass !== 1'b0) begin
      bad++; $display("FAIL stuck_count: err=%h pass=%b want 1 0", err_count, pass);
    end
    total++;
    if (first_err_addr !== 32'h8 || first_err_data !== 32'h2) begin
      bad++; $display("FAIL stuck_first: addr=%h data=%h want 8 2", first_err_addr, first_err_data);
    end
  endtask

  task automatic test_mode2_mode3;
    int cyc;
    clear_mem();
    run_start(2'd2);
    total++;
    if (done !== 1'b0 || err_count !== 16'h0 || first_err_addr !== 32'h0 || first_err_data !== 32'h0) begin
      bad++; $display("FAIL restart_clear: done=%b err=%h addr=%h data=%h want 0 0 0 0",
                      done, err_count, first_err_addr, first_err_data);
    end
    wait_done(200, cyc);
    total++;
    if (pass !== 1'b1) begin
      bad++; $display("FAIL mode2_pass: got %b want 1", pass);
    end
    for (int i = 0; i < NR; i++) begin
      total++;
      if (mem[i] !== ~32'(i + 1)) begin
        bad++; $display("FAIL mode2_mem%0d: got %h want %h", i, mem[i], ~32'(i + 1));
      end
    end
    run_start(2'd3);
    wait_done(200, cyc);
    total++;
    if (pass !== 1'b1) begin
      bad++; $display("FAIL mode3_pass: got %b want 1", pass);
    end
    for (int i = 0; i < NR; i++) begin
      total++;
      if (mem[i] !== 32'(4 * i)) begin
        bad++; $display("FAIL mode3_mem%0d: got %h want %h", i, mem[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    run_start(2'd0);
    repeat (3) @(negedge clk);
    mode = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, cyc);
    total++;
    if (pass !== 1'b1 || mem[0] !== 32'h1 || mem[3] !== 32'h4) begin
      bad++; $display("FAIL busy_start: pass=%b mem0=%h mem3=%h want 1 1 4", pass, mem[0], mem[3]);
    end
  endtask

`ifdef AXIL_SELFTEST_TIMEOUT_EN
  task automatic test_timeout;
    int n, cyc;
    ar_block = 1'b1;
    run_start(2'd0);
    cyc = 0;
    while (!bus.arvalid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    ar_block = 1'b0;
    total++;
    if (n !== 16) begin
      bad++; $display("FAIL timeout_latency: got %0d cycles want 16", n);
    end
    total++;
    if (err_count !== 16'd1 || bus.arvalid !== 1'b0 || pass !== 1'b0 || first_err_addr !== 32'h0) begin
      bad++; $display("FAIL timeout_result: err=%h arvalid=%b pass=%b addr=%h want 1 0 0 0",
                      err_count, bus.arvalid, pass, first_err_addr);
    end
  endtask
`else
  task automatic test_ar_stall;
    int cyc;
    ar_block = 1'b1;
    run_start(2'd0);
    cyc = 0;
    while (!bus.arvalid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (30) @(negedge clk);
    total++;
    if (bus.arvalid !== 1'b1 || busy !== 1'b1 || bus.araddr !== 32'h0) begin
      bad++; $display("FAIL ar_wait: arvalid=%b busy=%b araddr=%h want 1 1 0", bus.arvalid, busy, bus.araddr);
    end
    ar_block = 1'b0;
    wait_done(200, cyc);
    total++;
    if (pass !== 1'b1) begin
      bad++; $display("FAIL ar_stall_pass: got %b want 1", pass);
    end
  endtask
`endif

  task automatic test_reset_mid;
    int cyc;
    clear_mem();
    run_start(2'd0);
    cyc = 0;
    while (!(bus.bready && bus.awaddr == 32'h8) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (bus.bready !== 1'b1 || bus.awaddr !== 32'h8) begin
      bad++; $display("FAIL reach_wr_resp2: bready=%b awaddr=%h want 1 8", bus.bready, bus.awaddr);
    end
    rstn = 1'b0;
    @(negedge clk);
    check_reset_values("mid_reset");
    rstn = 1'b1;
    clear_mem();
    run_start(2'd0);
    wait_done(200, cyc);
    total++;
    if (cyc !== 17 || pass !== 1'b1 || mem[3] !== 32'h4) begin
      bad++; $display("FAIL after_reset: cycles=%0d pass=%b mem3=%h want 17 1 4", cyc, pass, mem[3]);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_zero_wait();
    test_stall_mode1();
    test_bresp_err();
    test_stuck_bit();
    test_mode2_mode3();
    test_start_while_busy();
`ifdef AXIL_SELFTEST_TIMEOUT_EN
    test_timeout();
`else
    test_ar_stall();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "global timeout");
  end
endmodule
